// File: rtl/free_list.sv
// Circular free list of physical register tags for a 2-wide rename stage.
// Speculative head allocates, tail reclaims retired T_old tags, arch_head supports mispredict rewind.
module free_list #(
  parameter  int PREG_NUMBER = 64,
  parameter  int ARCH_NUMBER = 32,
  parameter  int TAG_W       = $clog2(PREG_NUMBER),
  localparam int FL_SIZE     = PREG_NUMBER - ARCH_NUMBER,
  localparam int IDX_W       = $clog2(FL_SIZE),
  localparam int PTR_W       = IDX_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dispatch_en_i,
  input  logic             dispatch_size_i,
  input  logic [1:0]       retire_en_i,
  input  logic [TAG_W-1:0] T_old_i [2],
  input  logic             branch_mispredicted_i,
  output logic [TAG_W-1:0] freeReg_o [2],
  output logic             alloc_ok_o,
  output logic [1:0]       fl_status_o,
  output logic [PTR_W-1:0] free_count_o
`ifdef DEBUG
  ,
  output logic [IDX_W-1:0] head_debug,
  output logic [IDX_W-1:0] tail_debug
`endif
);

  localparam logic [1:0] ST_EMPTY    = 2'b00;
  localparam logic [1:0] ST_ONE_LEFT = 2'b01;
  localparam logic [1:0] ST_MORE     = 2'b10;

  logic [TAG_W-1:0] r_mem [FL_SIZE];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_arch_head;
  logic [PTR_W-1:0] r_tail;

  logic [PTR_W-1:0] w_count;
  logic [PTR_W-1:0] w_req;
  logic [PTR_W-1:0] w_nfree;
  logic [PTR_W-1:0] w_grant;
  logic [PTR_W-1:0] w_head_next;
  logic [IDX_W-1:0] w_head_idx;
  logic [IDX_W-1:0] w_head_p1_idx;
  logic [IDX_W-1:0] w_tail_idx;
  logic [IDX_W-1:0] w_tail_p1_idx;
  logic             w_alloc_ok;
  logic [PTR_W:0]   w_count_after;

  // Pointers carry a wrap bit, so the plain difference is the occupancy.
  assign w_count       = r_tail - r_head;
  assign w_head_idx    = r_head[IDX_W-1:0];
  assign w_head_p1_idx = w_head_idx + IDX_W'(1);
  assign w_tail_idx    = r_tail[IDX_W-1:0];
  assign w_tail_p1_idx = w_tail_idx + IDX_W'(1);

  assign w_req   = dispatch_en_i ? (dispatch_size_i ? PTR_W'(2) : PTR_W'(1)) : '0;
  assign w_nfree = PTR_W'(retire_en_i[0]) + PTR_W'(retire_en_i[1]);

  // All-or-nothing grant, judged against the current count only.
  assign w_alloc_ok = dispatch_en_i & (w_count >= w_req) & ~branch_mispredicted_i;
  assign w_grant    = w_alloc_ok ? w_req : '0;

  always_comb begin
    w_head_next = r_head + w_grant;
    if (branch_mispredicted_i) begin
      w_head_next = r_arch_head + w_nfree;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FL_SIZE; i++) begin
        r_mem[i] <= TAG_W'(ARCH_NUMBER + i);
      end
      r_head      <= '0;
      r_arch_head <= '0;
      r_tail      <= PTR_W'(FL_SIZE);
    end else begin
      if (retire_en_i[0]) begin
        r_mem[w_tail_idx] <= T_old_i[0];
      end
      if (retire_en_i[1]) begin
        r_mem[w_tail_p1_idx] <= T_old_i[1];
      end
      r_head      <= w_head_next;
      r_arch_head <= r_arch_head + w_nfree;
      r_tail      <= r_tail + w_nfree;
    end
  end

  assign freeReg_o[0] = r_mem[w_head_idx];
  assign freeReg_o[1] = r_mem[w_head_p1_idx];
  assign alloc_ok_o   = w_alloc_ok;
  assign free_count_o = w_count;

  always_comb begin
    fl_status_o = ST_MORE;
    if (w_count == '0) begin
      fl_status_o = ST_EMPTY;
    end else if (w_count == PTR_W'(1)) begin
      fl_status_o = ST_ONE_LEFT;
    end
  end

`ifdef DEBUG
  assign head_debug = w_head_idx;
  assign tail_debug = w_tail_idx;
`endif

  // Every freed tag was allocated earlier, so the list can never exceed its capacity.
  assign w_count_after = {1'b0, w_count} - {1'b0, w_grant} + {1'b0, w_nfree};

  a_no_overflow : assert property (@(posedge clk) disable iff (!reset)
    w_count_after <= (PTR_W + 1)'(FL_SIZE));

  a_retire_order : assert property (@(posedge clk) disable iff (!reset)
    !(retire_en_i[1] && !retire_en_i[0]));

endmodule
